// File: rtl/mux4_arb_pkg.sv
// Shared types, constants and helpers for the mux4 round-robin arbiter.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot2(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set req bit scanning ptr, ptr+1, ... mod 4.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic               found,
    output logic [1:0]         win
);

    always_comb begin
        logic [1:0] idx;
        // NOTE: default every output before the scan so no path leaves them unassigned (no latch).
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the mux4_1 select pair and a one-hot grant.
// Optional owner timeout is compiled in with `define MUX4_ARB_TIMEOUT_EN.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               s1,
    output logic               s0,
    output logic               busy,
    output logic [1:0]         owner
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_check
        $error("mux4_rr_arbiter: MAX_HOLD must be in 2..255");
    end

    state_t               state;
    logic [1:0]           sel;
    logic [1:0]           ptr;
    logic                 timeout_hit;
    logic                 handover;
    logic [NUM_REQ-1:0]   others;
    logic [NUM_REQ-1:0]   pick_req;
    logic [1:0]           pick_ptr;
    logic                 found;
    logic [1:0]           win;

    // The owner is excluded from the search, so a release or pre-emption never re-grants it.
    assign others   = req & ~onehot2(sel);
    assign handover = (state == GRANT) && (!req[sel] || timeout_hit);
    assign pick_req = (state == GRANT) ? others : req;
    assign pick_ptr = handover ? sel + 2'd1 : ptr;

    rr_pick4 u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .found (found),
        .win   (win)
    );

`ifdef MUX4_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    assign timeout_hit = (hold_cnt >= 8'(MAX_HOLD - 1)) && (|others);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 8'd0;
        end else if (state == IDLE || handover) begin
            hold_cnt <= 8'd0;
        end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= 2'd0;
            busy  <= 1'b0;
            ptr   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt   <= onehot2(win);
                        sel   <= win;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (handover) begin
                        ptr <= sel + 2'd1;
                        if (found) begin
                            gnt <= onehot2(win);
                            sel <= win;
                        end else begin
                            gnt   <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s1    = sel[1];
    assign s0    = sel[0];
    assign owner = sel;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (timeout scenario when MUX4_ARB_TIMEOUT_EN is defined).
module tb_mux4_rr_arbiter;

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam int TB_MAX_HOLD = 4;
`else
    localparam int TB_MAX_HOLD = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic       s1, s0, busy;
    logic [1:0] owner;

    int n_vec = 0;
    int n_bad = 0;

    mux4_rr_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .s1    (s1),
        .s0    (s0),
        .busy  (busy),
        .owner (owner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got t=%0t required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string name, input logic [3:0] exp_gnt,
                                input logic [1:0] exp_sel, input logic exp_busy);
        n_vec++;
        if ({gnt, s1, s0, busy, owner} !== {exp_gnt, exp_sel, exp_busy, exp_sel}) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b sel=%b%b busy=%b owner=%0d, required gnt=%b sel=%b busy=%b owner=%0d",
                     name, gnt, s1, s0, busy, owner, exp_gnt, exp_sel, exp_busy, exp_sel);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        #12;
        expect_state("reset_hold", 4'b0000, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        expect_state("reset_first_grant", 4'b0001, 2'b00, 1'b1);
    endtask

    // Starts with source 0 owning and ptr=0; each drop hands over with no bubble, wrapping 3->0.
    task automatic test_rotation();
        logic [3:0] exp_g [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_s [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic [3:0] drop  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int k = 0; k < 4; k++) begin
            req = drop[k];
            step();
            expect_state($sformatf("rotation_%0d", k), exp_g[k], exp_s[k], 1'b1);
            req = 4'b1111;
        end
        req = 4'b0000;
        step();
        expect_state("rotation_to_idle", 4'b0000, 2'b00, 1'b0);
    endtask

    // ptr is 1 here: source 3 wins over source 0, then release moves ptr to 0.
    task automatic test_skip_idle();
        req = 4'b1001;
        step();
        expect_state("skip_to_src3", 4'b1000, 2'b11, 1'b1);
        req = 4'b0001;
        step();
        expect_state("wrap_to_src0", 4'b0001, 2'b00, 1'b1);
        req = 4'b0000;
        step();
        expect_state("skip_idle_end", 4'b0000, 2'b00, 1'b0);
    endtask

    task automatic test_single();
        int bad = 0;
        req = 4'b0100;
        step();
        expect_state("single_grant", 4'b0100, 2'b10, 1'b1);
        for (int c = 0; c < 20; c++) begin
            step();
            if (gnt !== 4'b0100 || {s1, s0} !== 2'b10) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL single_hold: got %0d cycles off gnt=0100/sel=10 (last gnt=%b), required 0", bad, gnt);
        end
        req = 4'b0000;
        step();
        expect_state("single_release", 4'b0000, 2'b10, 1'b0);
    endtask

    // ptr is 3 here; a stale ptr would hand req=1001 to source 3 instead of 0 after reset.
    task automatic test_async_reset();
        req = 4'b0010;
        step();
        expect_state("pre_reset_grant", 4'b0010, 2'b01, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_state("async_reset_drop", 4'b0000, 2'b00, 1'b0);
        req = 4'b1001;
        #1;
        rst_n = 1'b1;
        step();
        expect_state("post_reset_ptr0", 4'b0001, 2'b00, 1'b1);
        req = 4'b0000;
        step();
        expect_state("post_reset_idle", 4'b0000, 2'b00, 1'b0);
    endtask

`ifdef MUX4_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int bad = 0;
        logic [3:0] exp_g;
        rst_n = 1'b0;
        req   = 4'b0011;
        #3;
        rst_n = 1'b1;
        step();
        for (int c = 0; c < 16; c++) begin
            exp_g = ((c / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
            if (c != 0) step();
            expect_state($sformatf("timeout_c%0d", c), exp_g, (exp_g == 4'b0001) ? 2'b00 : 2'b01, 1'b1);
        end
        req = 4'b0001;
        step();
        expect_state("timeout_lone_grant", 4'b0001, 2'b00, 1'b1);
        for (int c = 0; c < 20; c++) begin
            step();
            if (gnt !== 4'b0001) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL timeout_lone_hold: got %0d pre-empted cycles, required 0", bad);
        end
        req = 4'b0000;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_rotation();
        test_skip_idle();
        test_single();
        test_async_reset();
`ifdef MUX4_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux datapath between four requesters.
- Drives the mux select pair {s1,s0} and a one-hot grant vector, so exactly one source owns the mux output at a time.
- Sits in front of the team's mux4_1 datapath; requesters hold req high for as long as they need the path.

Parameters:
- MAX_HOLD, 8, maximum consecutive GRANT cycles before forced rotation. Used only when the timeout feature is compiled in; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request per source; bit k requests mux input ik
- gnt  output  4  one-hot grant, registered; all-zero when idle
- s1  output  1  mux select MSB, registered
- s0  output  1  mux select LSB, registered
- busy  output  1  high while any grant is active
- owner  output  2  index of current or last owner; equals {s1,s0}

Behaviour:
- Reset (async, rst_n=0) sets gnt=4'b0000, {s1,s0}=2'b00, busy=0, owner=0, state=IDLE and rotation pointer ptr=0 (ptr = index searched first). Reset mid-grant drops gnt immediately, without waiting for a clock edge.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, pick the first set bit scanning ptr, ptr+1, ... modulo 4.
  - Next edge: gnt=onehot(win), {s1,s0}=win, busy=1, go to GRANT.
  - Latency is 1 cycle from req sampled high to gnt.
  - If req==0, stay in IDLE. s1/s0/owner hold their last value.
- GRANT, owner k:
  - req[k]=1 (and no timeout): hold grant and select unchanged.
  - req[k]=0: set ptr=(k+1) mod 4 and arbitrate among the remaining req bits in the same cycle.
    - If a winner exists, the next edge grants it directly (back-to-back, no idle bubble) and the state stays GRANT.
    - Otherwise the next edge gives gnt=0, busy=0, state IDLE.
- Select changes only on the same edge as gnt changes, so gnt and {s1,s0} are always consistent.
- Simultaneous requests resolve strictly by rotation from ptr. No source wins twice in a row while another requester is pending at a release point.
- Pointer wrap: ptr=3 followed by release gives ptr=0.
- A request pulse shorter than one cycle between edges is not seen. No latching of requests.
- gnt is never multi-hot; busy == |gnt at all times.

Optional Feature:
- Macro: MUX4_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit hold counter clears on every new grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 and any other req bit is set, the owner is pre-empted. ptr=(k+1) mod 4 and the next edge grants the rotation winner.
  - A lone requester is never pre-empted; its counter saturates.
- When undefined: no counter logic, and the owner holds the grant indefinitely while req[k]=1.

Decomposition:
- Package mux4_arb_pkg:
  - state enum (IDLE, GRANT)
  - constant NUM_REQ=4
  - function onehot2 (2-bit to 4-bit one-hot)
- One sub-module, rr_pick4: combinational. Inputs req[3:0] and ptr[1:0]; outputs found and win[1:0].
- The top holds the FSM, ptr, registered outputs and the optional counter.

Test Plan:
- Reset: with rst_n=0 and req=4'b1111, gnt=0, {s1,s0}=00 and busy=0. Release reset and the first edge with req=1111 gives gnt=0001 and sel=00.
- Rotation: hold req=4'b1111 and drop each owner's bit for one cycle after grant. Grant sequence is 0001→0010→0100→1000→0001, and sel follows 00,01,10,11,00 with no idle cycle.
- Single requester: req=4'b0100 for 20 cycles gives gnt=0100 and sel=10 throughout. Drop req and the next edge gives gnt=0, busy=0, sel stays 10.
- Skip idle sources: with ptr=1 and req=4'b1001, the grant goes to source 3 (gnt=1000, sel=11). After release, ptr=0 and source 0 is granted.
- Async reset mid-grant: assert rst_n=0 between edges while gnt=0010. gnt must drop to 0 before the next edge; afterwards the first grant restarts from ptr=0.
- Timeout (MUX4_ARB_TIMEOUT_EN, MAX_HOLD=4): req=4'b0011 held constant gives source 0 for 4 cycles, then source 1 for 4 cycles, alternating. With only req=4'b0001, source 0 is never pre-empted.
